vec_inst_issue_queue: RTL and testbench
=======================================

Name: vec_inst_issue_queue

Overview:
- Parametrised instruction/operand issue queue between the scalar processor and the vector processor datapath/controller.
- Replaces the fixed two-entry instruction queue with a configurable-depth FIFO that has proper valid/ready on both sides, a same-cycle fall-through path, a flush, and an occupancy count.
- Each entry holds {instruction, rs1_data, rs2_data}.

Parameters:
- XLEN, 32, width of instruction, rs1_data and rs2_data.
- DEPTH, 4, number of entries; power of two, at least 2.
- CNT_W, $clog2(DEPTH)+1, width of the count output. Derived; do not override.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-low reset.
- inst_valid  input  1  scalar side: an entry is presented.
- inst_ready  output  1  queue can accept an entry.
- instruction  input  XLEN  instruction word.
- rs1_data  input  XLEN  scalar rs1 operand.
- rs2_data  input  XLEN  scalar rs2 operand.
- deq_valid  output  1  head entry is valid for the vector processor.
- deq_ready  input  1  vector processor takes the head (vec_pro_ready).
- deq_instruction  output  XLEN  head instruction.
- deq_rs1_data  output  XLEN  head rs1 operand.
- deq_rs2_data  output  XLEN  head rs2 operand.
- flush  input  1  discard all stored entries.
- count  output  CNT_W  number of stored entries.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Reset, sampled on the clk edge while reset==0:
  - write pointer, read pointer and count cleared to 0.
  - Entry storage is not cleared.
  - While reset==0: inst_ready=0, deq_valid=0, deq_* = 0, full=0, empty=1.
- Handshakes:
  - Enqueue fires when inst_valid && inst_ready.
  - Dequeue fires when deq_valid && deq_ready.
  - inst_ready = !full && !flush. It does not depend on deq_ready, so there is no combinational ready path. When full, the queue refuses input even if a dequeue happens in the same cycle.
  - The scalar side holds its inputs stable until the enqueue fires.
- Output when not empty: deq_valid=1 and deq_* = entry at the read pointer, with zero latency from state.
- Fall-through, only with VEC_IQ_BYPASS_EN:
  - Applies when empty && inst_valid && !flush.
  - deq_valid=1 and deq_* = instruction/rs1_data/rs2_data, combinationally in the same cycle.
  - If deq_ready=1 in that cycle, the entry is consumed directly: nothing is written and count stays 0.
  - If deq_ready=0, the entry is enqueued normally.
- Output when nothing is valid: deq_valid=0 and deq_* = 0.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Count update per cycle:
  - +1 on an enqueue that writes storage.
  - -1 on a dequeue from storage.
  - Unchanged when both happen in the same cycle (legal only when not full and not empty).
- flush, synchronous, priority over everything except reset:
  - Pointers and count cleared at the next edge.
  - In the flush cycle, deq_valid=0 and inst_ready=0; no enqueue or dequeue fires.
- Reset mid-operation: all stored entries are lost; identical to a flush.
- full and empty are combinational decodes of count. They are registered-consistent, with no glitches from the inputs.

Optional Feature:
- Macro: VEC_IQ_BYPASS_EN.
- Defined: the same-cycle fall-through described above; minimum latency is 0 cycles.
- Undefined:
  - Every entry is written to storage first.
  - deq_valid rises the cycle after the enqueue; minimum latency is 1 cycle.
  - An empty queue always has deq_valid=0.

Test Plan:
- Reset behaviour: hold reset=0 for 3 cycles, then release -> during reset inst_ready=0 and deq_valid=0; after release count=0, empty=1, inst_ready=1.
- Fill and drain, DEPTH=4, deq_ready=0: enqueue instructions 0x57, 0x58, 0x59, 0x5A with rs1=0x10..0x13 ->
  - count steps 1,2,3,4; full=1; inst_ready=0.
  - A fifth entry 0x5B is held and not accepted.
  - Then deq_ready=1 -> 0x57..0x5A dequeue in order; empty=1.
- Wrap-around: 10 enqueue/dequeue pairs with deq_ready=1 and a queue depth of 1-2 -> pointers wrap; the output sequence matches the input sequence exactly; count never exceeds 2.
- Fall-through: empty queue, inst_valid=1, deq_ready=1, instruction=0x0000_7057 ->
  - With VEC_IQ_BYPASS_EN: deq_instruction=0x0000_7057 and deq_valid=1 in the same cycle; count stays 0.
  - Without it: deq_valid=1 one cycle later.
- Flush: count=3, assert flush for one cycle together with inst_valid=1 ->
  - In the flush cycle, inst_ready=0 and deq_valid=0.
  - Next cycle count=0 and empty=1; the concurrent entry is not stored.
- Simultaneous enqueue and dequeue at count=2 -> count stays 2; the head advances; the new entry appears after the two older ones.

Source files
------------

// File: rtl/vec_inst_issue_queue.sv
// Instruction/operand issue queue between the scalar core and the vector datapath.
// Each entry is {instruction, rs1_data, rs2_data}. Valid/ready on both sides,
// synchronous flush, occupancy count.
// Optional feature: define VEC_IQ_BYPASS_EN for a same-cycle fall-through from
// the scalar inputs to the dequeue port when the queue is empty.
module vec_inst_issue_queue #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inst_valid,
  output logic             inst_ready,
  input  logic [XLEN-1:0]  instruction,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [XLEN-1:0]  deq_instruction,
  output logic [XLEN-1:0]  deq_rs1_data,
  output logic [XLEN-1:0]  deq_rs2_data,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned EntW = 3 * XLEN;

  // Entry storage; deliberately has no reset.
  logic [EntW-1:0]  mem_q [DEPTH];
  logic [EntW-1:0]  mem_d [DEPTH];

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             empty_int;
  logic             full_int;
  logic             bypass;
  logic             enq_fire;
  logic             deq_fire;
  logic             wr_en;
  logic             rd_en;
  logic [EntW-1:0]  head_entry;
  logic [EntW-1:0]  in_entry;

  assign in_entry   = {instruction, rs1_data, rs2_data};
  assign head_entry = mem_q[rd_ptr_q];

  // Status decode from registered count, plus the fall-through condition.
  always_comb begin
    empty_int = (count_q == '0);
    full_int  = (count_q == CNT_W'(DEPTH));
    bypass    = 1'b0;
`ifdef VEC_IQ_BYPASS_EN
    bypass    = empty_int && inst_valid && !flush;
`endif
  end

  // Handshake outputs; reset and flush both force the queue to look closed.
  always_comb begin
    inst_ready      = reset && !full_int && !flush;
    deq_valid       = 1'b0;
    deq_instruction = '0;
    deq_rs1_data    = '0;
    deq_rs2_data    = '0;
    if (reset && !flush) begin
      if (!empty_int) begin
        deq_valid = 1'b1;
        {deq_instruction, deq_rs1_data, deq_rs2_data} = head_entry;
      end else if (bypass) begin
        deq_valid = 1'b1;
        {deq_instruction, deq_rs1_data, deq_rs2_data} = in_entry;
      end
    end
    count = reset ? count_q : '0;
    full  = reset && full_int;
    empty = !reset || empty_int;
  end

  // Transfer decode: a bypassed entry taken the same cycle never touches storage.
  always_comb begin
    enq_fire = inst_valid && inst_ready;
    deq_fire = deq_valid && deq_ready;
    wr_en    = enq_fire && !(bypass && deq_ready);
    rd_en    = deq_fire && !empty_int;
  end

  // Pointer and count next state; flush dominates any transfer.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (rd_en) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage write at the write pointer.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr_en) begin
      mem_d[wr_ptr_q] = in_entry;
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage register update.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: tb/tb_vec_inst_issue_queue.sv
// Scoreboard bench for vec_inst_issue_queue (DEPTH=4, XLEN=32).
// Stimulus pushes expected entries; a negedge monitor pops and compares on every dequeue.
module tb_vec_inst_issue_queue;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 3;

  logic             clk;
  logic             reset;
  logic             inst_valid;
  logic             inst_ready;
  logic [XLEN-1:0]  instruction;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic             deq_valid;
  logic             deq_ready;
  logic [XLEN-1:0]  deq_instruction;
  logic [XLEN-1:0]  deq_rs1_data;
  logic [XLEN-1:0]  deq_rs2_data;
  logic             flush;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;

  vec_inst_issue_queue #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_dut (
    .clk             (clk),
    .reset           (reset),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .instruction     (instruction),
    .rs1_data        (rs1_data),
    .rs2_data        (rs2_data),
    .deq_valid       (deq_valid),
    .deq_ready       (deq_ready),
    .deq_instruction (deq_instruction),
    .deq_rs1_data    (deq_rs1_data),
    .deq_rs2_data    (deq_rs2_data),
    .flush           (flush),
    .count           (count),
    .full            (full),
    .empty           (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3*XLEN-1:0] exp_q [$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [3*XLEN-1:0] act,
                       input logic [3*XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every dequeue must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset === 1'b1 && deq_valid === 1'b1 && deq_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL deq_unexpected: got %0h expected none", deq_instruction);
      end else begin
        check("deq_entry", {deq_instruction, deq_rs1_data, deq_rs2_data}, exp_q.pop_front());
      end
    end
  end

  // Called at posedge+1 with inst_valid high; returns at posedge+1 after the enqueue fires.
  task automatic wait_accept(input string name);
    bit fired = 1'b0;
    for (int n = 0; n < 50 && !fired; n++) begin
      @(negedge clk);
      fired = inst_ready;
      @(posedge clk);
      #1;
    end
    check(name, {95'd0, fired}, 96'd1);
  endtask

  task automatic enqueue(input logic [XLEN-1:0] ins, input logic [XLEN-1:0] r1,
                         input logic [XLEN-1:0] r2);
    inst_valid  = 1'b1;
    instruction = ins;
    rs1_data    = r1;
    rs2_data    = r2;
    exp_q.push_back({ins, r1, r2});
    wait_accept("enq_accept");
    inst_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    bit done = 1'b0;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      done = empty;
      @(posedge clk);
      #1;
    end
    check(name, {95'd0, done}, 96'd1);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b0;
    inst_valid  = 1'b1;
    instruction = 32'h1234;
    rs1_data    = 32'h1;
    rs2_data    = 32'h2;
    deq_ready   = 1'b1;
    flush       = 1'b0;

    // Reset held for three cycles with a presented entry that must not leak out.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_inst_ready", {95'd0, inst_ready}, 96'd0);
      check("rst_deq_valid", {95'd0, deq_valid}, 96'd0);
      check("rst_deq_instr", {64'd0, deq_instruction}, 96'd0);
      check("rst_empty_full", {94'd0, empty, full}, {94'd0, 2'b10});
    end
    @(posedge clk);
    #1;
    reset      = 1'b1;
    inst_valid = 1'b0;
    @(negedge clk);
    check("post_rst_count", {93'd0, count}, 96'd0);
    check("post_rst_empty", {95'd0, empty}, 96'd1);
    check("post_rst_inst_ready", {95'd0, inst_ready}, 96'd1);
    cycle();

    // Fill to full with no dequeues.
    deq_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      enqueue(32'h57 + i, 32'h10 + i, 32'h20 + i);
      check("fill_count", {93'd0, count}, 96'(i + 1));
    end
    check("fill_full", {95'd0, full}, 96'd1);
    check("fill_inst_ready", {95'd0, inst_ready}, 96'd0);

    // Fifth entry is held off while full.
    inst_valid  = 1'b1;
    instruction = 32'h5B;
    rs1_data    = 32'h14;
    rs2_data    = 32'h24;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("full_hold_ready", {95'd0, inst_ready}, 96'd0);
      check("full_head", {64'd0, deq_instruction}, 96'h57);
      cycle();
    end
    check("full_hold_count", {93'd0, count}, 96'd4);

    // Drain; the held entry goes in once space frees up and comes out last.
    exp_q.push_back({32'h5B, 32'h14, 32'h24});
    deq_ready = 1'b1;
    wait_accept("held_accept");
    inst_valid = 1'b0;
    wait_empty("drain_empty");
    check("drain_sb_empty", 96'(exp_q.size()), 96'd0);

    // Back-to-back traffic wraps both pointers.
    for (int i = 0; i < 10; i++) begin
      enqueue(32'hA00 + i, 32'hB00 + i, 32'hC00 + i);
      check("wrap_count_le2", {95'd0, (count <= 2)}, 96'd1);
    end
    wait_empty("wrap_empty");
    check("wrap_sb_empty", 96'(exp_q.size()), 96'd0);

    // Fall-through from an empty queue.
    inst_valid  = 1'b1;
    instruction = 32'h0000_7057;
    rs1_data    = 32'h77;
    rs2_data    = 32'h88;
    exp_q.push_back({32'h0000_7057, 32'h77, 32'h88});
    @(negedge clk);
`ifdef VEC_IQ_BYPASS_EN
    check("ft_deq_valid", {95'd0, deq_valid}, 96'd1);
    check("ft_deq_instr", {64'd0, deq_instruction}, 96'h7057);
`else
    check("ft_deq_valid", {95'd0, deq_valid}, 96'd0);
`endif
    cycle();
    inst_valid = 1'b0;
`ifdef VEC_IQ_BYPASS_EN
    check("ft_count", {93'd0, count}, 96'd0);
`else
    check("ft_count", {93'd0, count}, 96'd1);
    @(negedge clk);
    check("ft_late_valid", {95'd0, deq_valid}, 96'd1);
    cycle();
`endif
    check("ft_sb_empty", 96'(exp_q.size()), 96'd0);

    // Flush at count=3 with a concurrent enqueue attempt.
    deq_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      enqueue(32'hF0 + i, 32'hF1, 32'hF2);
    end
    check("pre_flush_count", {93'd0, count}, 96'd3);
    flush       = 1'b1;
    inst_valid  = 1'b1;
    instruction = 32'hDEAD;
    @(negedge clk);
    check("flush_inst_ready", {95'd0, inst_ready}, 96'd0);
    check("flush_deq_valid", {95'd0, deq_valid}, 96'd0);
    cycle();
    flush      = 1'b0;
    inst_valid = 1'b0;
    exp_q.delete();
    check("post_flush_count", {93'd0, count}, 96'd0);
    check("post_flush_empty", {95'd0, empty}, 96'd1);
    @(negedge clk);
    check("post_flush_deq_valid", {95'd0, deq_valid}, 96'd0);
    cycle();

    // Simultaneous enqueue and dequeue at count=2.
    enqueue(32'h301, 32'h1, 32'h2);
    enqueue(32'h302, 32'h3, 32'h4);
    check("simul_pre_count", {93'd0, count}, 96'd2);
    deq_ready   = 1'b1;
    inst_valid  = 1'b1;
    instruction = 32'h303;
    rs1_data    = 32'h5;
    rs2_data    = 32'h6;
    exp_q.push_back({32'h303, 32'h5, 32'h6});
    @(negedge clk);
    check("simul_head_a", {64'd0, deq_instruction}, 96'h301);
    check("simul_ready", {95'd0, inst_ready}, 96'd1);
    cycle();
    deq_ready  = 1'b0;
    inst_valid = 1'b0;
    check("simul_count", {93'd0, count}, 96'd2);
    @(negedge clk);
    check("simul_head_b", {64'd0, deq_instruction}, 96'h302);
    cycle();
    deq_ready = 1'b1;
    wait_empty("simul_empty");
    check("simul_sb_empty", 96'(exp_q.size()), 96'd0);

    // Reset in the middle of operation drops stored entries.
    deq_ready = 1'b0;
    enqueue(32'h401, 32'h1, 32'h1);
    enqueue(32'h402, 32'h2, 32'h2);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_inst_ready", {95'd0, inst_ready}, 96'd0);
    cycle();
    reset = 1'b1;
    exp_q.delete();
    check("midrst_count", {93'd0, count}, 96'd0);
    @(negedge clk);
    check("midrst_deq_valid", {95'd0, deq_valid}, 96'd0);
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
